fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//  Consumer side of the program counter: reads the PC value, fetches the instruction from instruction
//  memory over a req/ack handshake, and holds it in a one-entry buffer for decode (valid/ready).
//  Drives the PC's write port (pc_next/pc_enable) to advance or redirect it.
//  Sits between the PC register, the instruction memory port and the decode stage.
// PARAMETERS
//  WIDTH        32  address/instruction width in bits
//  INSTR_BYTES  4   sequential PC increment per accepted instruction
// PORTS
//  clk             in   1      clock, all state updates on rising edge
//  rst             in   1      synchronous reset, active-high
//  fetch_en        in   1      1 = fetching allowed; 0 = hold in IDLE once current fetch drains
//  pc_value        in   WIDTH  current PC register output
//  pc_next         out  WIDTH  value to write into the PC
//  pc_enable       out  1      PC write strobe (combinational, one cycle)
//  redirect_valid  in   1      branch/jump redirect request, single cycle
//  redirect_addr   in   WIDTH  redirect target
//  imem_req        out  1      memory read request
//  imem_addr       out  WIDTH  memory read address, stable while imem_req=1
//  imem_ack        in   1      memory read done; imem_rdata valid this cycle
//  imem_rdata      in   WIDTH  read instruction word
//  instr_valid     out  1      buffered instruction available to decode
//  instr_ready     in   1      decode accepts instruction
//  instr_data      out  WIDTH  buffered instruction
//  instr_pc        out  WIDTH  address of buffered instruction
// BEHAVIOUR
//  - Reset (sync): state=IDLE, fetch_addr=0, squash=0, instr_data=0, instr_pc=0.
//    Outputs imem_req=0, instr_valid=0, pc_enable=0.
//  - FSM IDLE -> REQ: taken when fetch_en=1.
//  - FSM REQ: imem_req=1, imem_addr=fetch_addr.
//    On imem_ack with squash=0 and no redirect: buffer rdata/fetch_addr, go to HOLD.
//  - FSM HOLD: instr_valid=1. On instr_valid&&instr_ready: pc_enable=1, pc_next=instr_pc+INSTR_BYTES.
//    Sum is computed modulo 2^WIDTH (wraps silently). Next state is REQ if fetch_en, else IDLE.
//  - fetch_addr latch on every entry to REQ: fetch_addr <= pc_enable ? pc_next : pc_value.
//    This makes the new PC visible to memory without an extra cycle.
//  - Redirect handling:
//    - Any state: redirect_valid forces pc_enable=1, pc_next=redirect_addr. Redirect wins over sequential update.
//    - IDLE: stays IDLE if fetch_en=0; otherwise enters REQ with fetch_addr=redirect_addr.
//    - REQ without ack: the bus transaction is not cancelled. imem_addr stays unchanged, squash<=1.
//      On ack, discard rdata, clear squash, re-enter REQ at the new PC.
//    - REQ with same-cycle ack: discard rdata, re-enter REQ with fetch_addr=redirect_addr.
//    - HOLD: buffered instruction dropped, so instr_valid=0 next cycle; enter REQ at redirect_addr.
//      If instr_ready is also high that cycle, the handshake counts as completed
//      (decode consumed it) but pc_next is still redirect_addr.
//  - fetch_en=0 in REQ: request completes, instruction is buffered (HOLD); IDLE after it is consumed.
//  - Latency: IDLE->REQ 1 cycle. Ack -> instr_valid next cycle.
//    Handshake -> next imem_req next cycle. Minimum 2 cycles per instruction with 0-wait memory.
//  - rst mid-operation: drops outstanding request/buffer immediately.
//    The memory must tolerate a deasserted req without ack.
//  - instr_data/instr_pc are stable while instr_valid=1 and instr_ready=0.
// TESTING
//  1. rst 2 cycles, PC=0x0, fetch_en=1, ack after 1 wait, rdata=0xDEADBEEF
//     -> imem_addr=0x0; instr_valid with data 0xDEADBEEF/pc 0x0; on ready pc_enable=1, pc_next=0x4.
//  2. Back-to-back with instr_ready=1, 0-wait ack -> fetch addresses 0x0, 0x4, 0x8, 0xC, one per 2 cycles.
//  3. instr_ready=0 for 5 cycles in HOLD -> instr_valid, data and pc held constant; no new imem_req.
//  4. redirect_valid to 0x100 while REQ waiting for ack
//     -> imem_addr unchanged until ack; that rdata never appears on instr_valid; next imem_addr=0x100.
//  5. redirect to 0x200 in HOLD with instr_ready=1 same cycle -> pc_next=0x200 (not pc+4); next fetch at 0x200.
//  6. PC=0xFFFFFFFC accepted -> pc_next=0x00000000 (wrap). rst asserted in REQ -> imem_req=0 next cycle, state IDLE.

Source files
------------

// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
//
// Purpose:
//   Consumer side of the program counter. Reads the current PC and fetches
//   the instruction word from instruction memory over a req/ack handshake.
//   Holds the word in a one-entry buffer and offers it to decode with a
//   valid/ready handshake. Drives the PC write port, either to advance the PC
//   sequentially or to redirect it on a branch/jump.
//
// Ports:
//   clk            - clock, all state updates on the rising edge
//   rst            - synchronous reset, active-high
//   fetch_en       - 1 allows fetching; 0 parks in IDLE once the current fetch drains
//   pc_value       - current PC register output
//   pc_next        - value to write into the PC
//   pc_enable      - PC write strobe (combinational, one cycle)
//   redirect_valid - branch/jump redirect request (single cycle)
//   redirect_addr  - redirect target
//   imem_req       - memory read request
//   imem_addr      - memory read address, stable while imem_req=1
//   imem_ack       - memory read done, imem_rdata valid this cycle
//   imem_rdata     - instruction word read from memory
//   instr_valid    - buffered instruction available to decode
//   instr_ready    - decode accepts the buffered instruction
//   instr_data     - buffered instruction word
//   instr_pc       - address of the buffered instruction
// ----------------------------------------------------------------------------
module fetch_unit #(
  parameter int WIDTH       = 32,
  parameter int INSTR_BYTES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fetch_en,
  input  logic [WIDTH-1:0] pc_value,
  output logic [WIDTH-1:0] pc_next,
  output logic             pc_enable,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_addr,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [WIDTH-1:0] instr_data,
  output logic [WIDTH-1:0] instr_pc
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] fetch_addr;
  logic             squash;

  logic             load_fetch;
  logic             capture;
  logic             set_squash;
  logic             clr_squash;

  // Next-state and output decode. A redirect overrides the PC write port in
  // every state, after the per-state sequential update has been decided.
  // A redirect while a memory read is outstanding cannot cancel the bus
  // transaction, so it only marks the in-flight word for discard (squash).
  always_comb begin
    state_nxt   = state;
    pc_enable   = 1'b0;
    pc_next     = instr_pc + WIDTH'(INSTR_BYTES);
    imem_req    = 1'b0;
    imem_addr   = fetch_addr;
    instr_valid = 1'b0;
    load_fetch  = 1'b0;
    capture     = 1'b0;
    set_squash  = 1'b0;
    clr_squash  = 1'b0;

    case (state)
      IDLE: begin
        if (fetch_en) begin
          state_nxt  = REQ;
          load_fetch = 1'b1;
        end
      end

      REQ: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          if (squash || redirect_valid) begin
            clr_squash = 1'b1;
            state_nxt  = REQ;
            load_fetch = 1'b1;
          end else begin
            capture   = 1'b1;
            state_nxt = HOLD;
          end
        end else if (redirect_valid) begin
          set_squash = 1'b1;
        end
      end

      HOLD: begin
        instr_valid = 1'b1;
        if (redirect_valid) begin
          state_nxt  = REQ;
          load_fetch = 1'b1;
        end else if (instr_ready) begin
          pc_enable  = 1'b1;
          state_nxt  = fetch_en ? REQ : IDLE;
          load_fetch = fetch_en;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (redirect_valid) begin
      pc_enable = 1'b1;
      pc_next   = redirect_addr;
    end
  end

  // State, fetch address, squash flag and instruction buffer. On entry to REQ
  // the fetch address takes the value being written into the PC this cycle,
  // if any, so memory sees the new PC without waiting for the PC register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      fetch_addr <= '0;
      squash     <= 1'b0;
      instr_data <= '0;
      instr_pc   <= '0;
    end else begin
      state <= state_nxt;
      if (load_fetch) begin
        fetch_addr <= pc_enable ? pc_next : pc_value;
      end
      if (set_squash) begin
        squash <= 1'b1;
      end else if (clr_squash) begin
        squash <= 1'b0;
      end
      if (capture) begin
        instr_data <= imem_rdata;
        instr_pc   <= fetch_addr;
      end
    end
  end

endmodule
